uart_core_param: RTL

- Parametrised single-clock UART transceiver. Successor to the fixed 8N1 UART front end.
- Provides a runtime baud divisor, runtime parity and stop-bit selection, and a parametrised data width.
- Contains depth-parametrised synchronous RX/TX FIFOs and sticky error flags.
- Sits beside the load/store path: the CPU pushes TX bytes with a write strobe and pops RX bytes with a read strobe.

---
 rtl/uart_core_param.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: single-clock UART transceiver with runtime baud/parity/stop config,
// show-ahead RX/TX FIFOs and sticky error flags.
module uart_core_param_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

module uart_core_param #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_write,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_read,
  output logic [31:0]          rx_data,
  input  logic                 err_clear,
  output logic [7:0]           status
);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t ts, rs;
  logic [DIV_WIDTH-1:0] div_eff, t_cnt, t_div, r_cnt, r_div;
  logic pen, odd;
  logic [DATA_BITS-1:0] tf_dout, rf_dout, t_sh, r_sh;
  logic tf_full, tf_empty, tf_pop, rf_full, rf_empty;
  logic [BW-1:0] t_bit, r_bit;
  logic t_par, t_pen, t_stop2, t_stopn, t_last;
  logic s1, s2, s2d, r_pen, r_odd, r_par, r_push, r_last;
  logic stop_hit, fe_set, pe_set, ov_set, ferr, perr, ovr;
  assign div_eff = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;
  assign pen = ^parity_mode;
  assign odd = parity_mode[1];
  assign tf_pop = ts == IDLE && !tf_empty;
  assign t_last = t_cnt == '0;
  assign r_last = r_cnt == '0;
  uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_write), .pop(tf_pop), .din(tx_data),
    .dout(tf_dout), .full(tf_full), .empty(tf_empty)
  );
  uart_core_param_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(r_push), .pop(rx_read), .din(r_sh),
    .dout(rf_dout), .full(rf_full), .empty(rf_empty)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ts <= IDLE;
      tx <= 1'b1;
      t_cnt <= '0;
      t_div <= '0;
      t_sh <= '0;
      t_bit <= '0;
      t_par <= 1'b0;
      t_pen <= 1'b0;
      t_stop2 <= 1'b0;
      t_stopn <= 1'b0;
    end else begin
      if (ts != IDLE) t_cnt <= t_last ? t_div - ONE : t_cnt - ONE;
      case (ts)
        IDLE: if (!tf_empty) begin
          ts <= START;
          tx <= 1'b0;
          t_sh <= tf_dout;
          t_par <= ^tf_dout ^ odd;
          t_pen <= pen;
          t_stop2 <= stop2;
          t_stopn <= 1'b0;
          t_bit <= '0;
          t_div <= div_eff;
          t_cnt <= div_eff - ONE;
        end
        START: if (t_last) begin
          ts <= DATA;
          tx <= t_sh[0];
        end
        DATA: if (t_last) begin
          if (t_bit == BW'(DATA_BITS - 1)) begin
            ts <= t_pen ? PARITY : STOP;
            tx <= t_pen ? t_par : 1'b1;
          end else begin
            t_sh <= t_sh >> 1;
            tx <= t_sh[1];
            t_bit <= t_bit + BW'(1);
          end
        end
        PARITY: if (t_last) begin
          ts <= STOP;
          tx <= 1'b1;
        end
        STOP: if (t_last) begin
          if (t_stop2 && !t_stopn) t_stopn <= 1'b1;
          else ts <= IDLE;
        end
        default: ts <= IDLE;
      endcase
    end
  // Stop sample decides the character's fate; a good one is pushed the next cycle.
  assign stop_hit = rs == STOP && r_last;
  assign fe_set = stop_hit && !s2;
  assign pe_set = stop_hit && r_pen && (r_par != (^r_sh ^ r_odd));
  assign ov_set = r_push && rf_full && !rx_read;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rs <= IDLE;
      s1 <= 1'b1;
      s2 <= 1'b1;
      s2d <= 1'b1;
      r_cnt <= '0;
      r_div <= '0;
      r_sh <= '0;
      r_bit <= '0;
      r_pen <= 1'b0;
      r_odd <= 1'b0;
      r_par <= 1'b0;
      r_push <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s2d <= s2;
      r_push <= stop_hit && !fe_set && !pe_set;
      if (rs != IDLE) r_cnt <= r_last ? r_div - ONE : r_cnt - ONE;
      case (rs)
        IDLE: if (s2d && !s2) begin
          rs <= START;
          r_div <= div_eff;
          r_pen <= pen;
          r_odd <= odd;
          r_bit <= '0;
          r_cnt <= (div_eff >> 1) - ONE;
        end
        START: if (r_last) rs <= s2 ? IDLE : DATA;
        DATA: if (r_last) begin
          r_sh <= {s2, r_sh[DATA_BITS-1:1]};
          r_bit <= r_bit + BW'(1);
          if (r_bit == BW'(DATA_BITS - 1)) rs <= r_pen ? PARITY : STOP;
        end
        PARITY: if (r_last) begin
          r_par <= s2;
          rs <= STOP;
        end
        STOP: if (r_last) rs <= IDLE;
        default: rs <= IDLE;
      endcase
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ferr <= 1'b0;
      perr <= 1'b0;
      ovr <= 1'b0;
    end else begin
      ferr <= (ferr && !err_clear) || fe_set;
      perr <= (perr && !err_clear) || pe_set;
      ovr <= (ovr && !err_clear) || ov_set;
    end
  assign rx_data = rf_empty ? 32'hFFFF_FFFF : 32'(rf_dout);
  assign status = {ts != IDLE, tf_full, tf_empty, rf_full, rf_empty, ovr, perr, ferr};
endmodule
